// File: rtl/pong_pkg.sv
// Shared encodings for the Pong screen controller: screens, icon rows, speeds and
// the single winning button command decoded from simultaneous edges.
package pong_pkg;

  typedef enum logic [1:0] {
    SCR_MENU    = 2'b00,
    SCR_GAME    = 2'b01,
    SCR_CREDITS = 2'b10,
    SCR_OPTIONS = 2'b11
  } screen_e;

  localparam logic [1:0] ICON_MENU_PLAY    = 2'd0;
  localparam logic [1:0] ICON_MENU_OPTIONS = 2'd1;
  localparam logic [1:0] ICON_MENU_CREDITS = 2'd2;
  localparam logic [1:0] ICON_OPT_SPEED    = 2'd0;
  localparam logic [1:0] ICON_OPT_BACK     = 2'd1;

  localparam logic [1:0] SPD_SLOW   = 2'b00;
  localparam logic [1:0] SPD_NORMAL = 2'b01;
  localparam logic [1:0] SPD_FAST   = 2'b10;

  typedef enum logic [2:0] {
    CmdNone,
    CmdBack,
    CmdSelect,
    CmdUp,
    CmdDown
  } cmd_e;

  function automatic logic [1:0] next_speed(input logic [1:0] spd);
    case (spd)
      SPD_SLOW:   return SPD_NORMAL;
      SPD_NORMAL: return SPD_FAST;
      default:    return SPD_SLOW;
    endcase
  endfunction

  // Edge vector order is {back, select, up, down}; up together with down cancels.
  function automatic cmd_e decode_cmd(input logic [3:0] rise);
    if (rise[3]) return CmdBack;
    if (rise[2]) return CmdSelect;
    if (rise[1] && rise[0]) return CmdNone;
    if (rise[1]) return CmdUp;
    if (rise[0]) return CmdDown;
    return CmdNone;
  endfunction

endpackage

// File: rtl/pong_edge_det.sv
// Registers a vector of levels and flags rising edges (current 1, previous 0).
module pong_edge_det #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] cur_q;
  logic [Width-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= d_i;
      prev_q <= cur_q;
    end
  end

  assign rise_o = cur_q & ~prev_q;

endmodule

// File: rtl/pong_screen_ctl.sv
// Screen sequencer for the Pong display path; screen changes commit on a vblank edge.
// Define PONG_SCREEN_IDLE_TIMEOUT_EN to return to MENU after IDLE_FRAMES without input.
module pong_screen_ctl
  import pong_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES   = 120,
  parameter int unsigned IDLE_FRAMES   = 1800,
  parameter logic [1:0]  SPEED_DEFAULT = 2'b01
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       btn_back,
  input  logic       game_over,
  output logic [1:0] screen_mode,
  output logic [1:0] icon_highlighter,
  output logic [1:0] speed_selector,
  output logic       game_run,
  output logic       game_reset
);

  localparam int unsigned   HW       = $clog2(HOLD_FRAMES + 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  logic [3:0] btn_rise;
  logic       vblnk_rise;
  cmd_e       cmd;

  pong_edge_det #(.Width(4)) u_btn_edge (
    .clk_i  (pclk),
    .rst_i  (rst),
    .d_i    ({btn_back, btn_select, btn_up, btn_down}),
    .rise_o (btn_rise)
  );

  pong_edge_det #(.Width(1)) u_vblnk_edge (
    .clk_i  (pclk),
    .rst_i  (rst),
    .d_i    (vblnk),
    .rise_o (vblnk_rise)
  );

  assign cmd = decode_cmd(btn_rise);

  screen_e       mode_q, mode_d, tgt_mode_q, tgt_mode_d;
  logic [1:0]    icon_q, icon_d, tgt_icon_q, tgt_icon_d, speed_q, speed_d;
  logic          pend_q, pend_d, hold_act_q, hold_act_d, game_reset_q, game_reset_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

`ifdef PONG_SCREEN_IDLE_TIMEOUT_EN
  localparam int unsigned   IW       = $clog2(IDLE_FRAMES + 2);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_FRAMES);
  logic [IW-1:0] idle_q, idle_d;

  always_ff @(posedge pclk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = ^IDLE_FRAMES;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      mode_q       <= SCR_MENU;
      icon_q       <= '0;
      speed_q      <= SPEED_DEFAULT;
      pend_q       <= 1'b0;
      tgt_mode_q   <= SCR_MENU;
      tgt_icon_q   <= '0;
      hold_act_q   <= 1'b0;
      hold_cnt_q   <= '0;
      game_reset_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      icon_q       <= icon_d;
      speed_q      <= speed_d;
      pend_q       <= pend_d;
      tgt_mode_q   <= tgt_mode_d;
      tgt_icon_q   <= tgt_icon_d;
      hold_act_q   <= hold_act_d;
      hold_cnt_q   <= hold_cnt_d;
      game_reset_q <= game_reset_d;
    end
  end

  always_comb begin
    mode_d       = mode_q;
    icon_d       = icon_q;
    speed_d      = speed_q;
    pend_d       = pend_q;
    tgt_mode_d   = tgt_mode_q;
    tgt_icon_d   = tgt_icon_q;
    hold_act_d   = hold_act_q;
    hold_cnt_d   = hold_cnt_q;
    game_reset_d = 1'b0;

    if (pend_q) begin
      // Buttons are ignored while a change waits for the next frame boundary.
      if (vblnk_rise) begin
        mode_d       = tgt_mode_q;
        icon_d       = tgt_icon_q;
        pend_d       = 1'b0;
        hold_act_d   = 1'b0;
        hold_cnt_d   = '0;
        game_reset_d = (tgt_mode_q == SCR_GAME);
      end
    end else begin
      unique case (mode_q)
        SCR_MENU: begin
          case (cmd)
            CmdDown: icon_d = (icon_q == ICON_MENU_CREDITS) ? ICON_MENU_PLAY : icon_q + 2'd1;
            CmdUp:   icon_d = (icon_q == ICON_MENU_PLAY) ? ICON_MENU_CREDITS : icon_q - 2'd1;
            CmdSelect: begin
              pend_d     = 1'b1;
              tgt_icon_d = '0;
              if (icon_q == ICON_MENU_PLAY)         tgt_mode_d = SCR_GAME;
              else if (icon_q == ICON_MENU_OPTIONS) tgt_mode_d = SCR_OPTIONS;
              else                                  tgt_mode_d = SCR_CREDITS;
            end
            default: ;
          endcase
        end
        SCR_OPTIONS: begin
          case (cmd)
            CmdUp, CmdDown: icon_d = (icon_q == ICON_OPT_SPEED) ? ICON_OPT_BACK : ICON_OPT_SPEED;
            CmdSelect, CmdBack: begin
              if (cmd == CmdSelect && icon_q == ICON_OPT_SPEED) begin
                speed_d = next_speed(speed_q);
              end else begin
                pend_d     = 1'b1;
                tgt_mode_d = SCR_MENU;
                tgt_icon_d = ICON_MENU_OPTIONS;
              end
            end
            default: ;
          endcase
        end
        SCR_CREDITS: begin
          if (cmd == CmdSelect || cmd == CmdBack) begin
            pend_d     = 1'b1;
            tgt_mode_d = SCR_MENU;
            tgt_icon_d = ICON_MENU_CREDITS;
          end
        end
        SCR_GAME: begin
          if (cmd == CmdBack || (hold_act_q && hold_cnt_q == HOLD_MAX)) begin
            pend_d     = 1'b1;
            tgt_mode_d = SCR_MENU;
            tgt_icon_d = ICON_MENU_PLAY;
          end
          if (hold_act_q) begin
            if (vblnk_rise && hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HW'(1);
          end else if (game_over) begin
            hold_act_d = 1'b1;
            hold_cnt_d = '0;
          end
        end
      endcase
    end

`ifdef PONG_SCREEN_IDLE_TIMEOUT_EN
    idle_d = idle_q;
    if (|btn_rise || (pend_q && vblnk_rise)) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      idle_d = '0;
      if (mode_q == SCR_MENU) begin
        icon_d = ICON_MENU_PLAY;
      end else if (mode_q != SCR_GAME && !pend_q) begin
        pend_d     = 1'b1;
        tgt_mode_d = SCR_MENU;
        tgt_icon_d = ICON_MENU_PLAY;
      end
    end else if (mode_q != SCR_GAME && vblnk_rise) begin
      idle_d = idle_q + IW'(1);
    end
`endif
  end

  always_comb begin
    screen_mode      = mode_q;
    icon_highlighter = icon_q;
    speed_selector   = speed_q;
    game_reset       = game_reset_q;
    game_run         = (mode_q == SCR_GAME) && !pend_q && !hold_act_q;
  end

endmodule

// File: tb/tb_pong_screen_ctl.sv
// Self-checking bench for pong_screen_ctl: directed scenarios plus a randomized event
// stream checked against an event-level reference model.
module tb_pong_screen_ctl;

  localparam int unsigned HOLD = 3;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       vblnk = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_select = 1'b0, btn_back = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] screen_mode, icon_highlighter, speed_selector;
  logic       game_run, game_reset;

  int n_tests = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  pong_screen_ctl #(
    .HOLD_FRAMES   (HOLD),
    .IDLE_FRAMES   (1800),
    .SPEED_DEFAULT (2'b01)
  ) dut (
    .pclk             (pclk),
    .rst              (rst),
    .vblnk            (vblnk),
    .btn_up           (btn_up),
    .btn_down         (btn_down),
    .btn_select       (btn_select),
    .btn_back         (btn_back),
    .game_over        (game_over),
    .screen_mode      (screen_mode),
    .icon_highlighter (icon_highlighter),
    .speed_selector   (speed_selector),
    .game_run         (game_run),
    .game_reset       (game_reset)
  );

  // Reference model: screens 0 MENU, 1 GAME, 2 CREDITS, 3 OPTIONS; hold -1 means idle.
  int m_mode, m_icon, m_speed, m_tgt_mode, m_tgt_icon, m_hold;
  bit m_pend, m_greset;

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // One-cycle event; on return the DUT reaction is visible. btns = {back, select, up, down}.
  task automatic pulse(input logic [3:0] btns, input logic vb, input logic go);
    {btn_back, btn_select, btn_up, btn_down} = btns;
    vblnk = vb;
    game_over = go;
    @(negedge pclk);
    {btn_back, btn_select, btn_up, btn_down} = 4'b0000;
    vblnk = 1'b0;
    game_over = 1'b0;
    @(negedge pclk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic model_reset();
    m_mode = 0; m_icon = 0; m_speed = 1; m_pend = 0;
    m_tgt_mode = 0; m_tgt_icon = 0; m_hold = -1; m_greset = 0;
  endtask

  task automatic model_set_pending(input int mode, input int icon);
    m_pend = 1; m_tgt_mode = mode; m_tgt_icon = icon;
  endtask

  task automatic model_btn(input logic [3:0] m);
    int act;
    m_greset = 0;
    if (m_pend) return;
    if (m[3]) act = 1;
    else if (m[2]) act = 2;
    else if (m[1] && m[0]) act = 0;
    else if (m[1]) act = 3;
    else if (m[0]) act = 4;
    else act = 0;
    case (m_mode)
      0: begin
        if (act == 4) m_icon = (m_icon + 1) % 3;
        else if (act == 3) m_icon = (m_icon + 2) % 3;
        else if (act == 2) model_set_pending(m_icon == 0 ? 1 : (m_icon == 1 ? 3 : 2), 0);
      end
      3: begin
        if (act == 3 || act == 4) m_icon = 1 - m_icon;
        else if (act == 2 && m_icon == 0) m_speed = (m_speed + 1) % 3;
        else if (act == 1 || act == 2) model_set_pending(0, 1);
      end
      2: if (act == 1 || act == 2) model_set_pending(0, 2);
      default: if (act == 1) model_set_pending(0, 0);
    endcase
  endtask

  task automatic model_vblnk();
    m_greset = 0;
    if (m_pend) begin
      m_mode = m_tgt_mode; m_icon = m_tgt_icon; m_pend = 0; m_hold = -1;
      m_greset = (m_mode == 1);
    end else if (m_mode == 1 && m_hold >= 0) begin
      if (m_hold < HOLD) m_hold++;
      if (m_hold == HOLD) model_set_pending(0, 0);
    end
  endtask

  task automatic model_game_over();
    m_greset = 0;
    if (m_mode == 1 && !m_pend && m_hold < 0) m_hold = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode got %b exp 00", screen_mode); end
    n_tests++; if (icon_highlighter !== 2'b00) begin n_fail++; $display("FAIL reset_icon got %b exp 00", icon_highlighter); end
    n_tests++; if (speed_selector !== 2'b01) begin n_fail++; $display("FAIL reset_speed got %b exp 01", speed_selector); end
    n_tests++; if (game_run !== 1'b0) begin n_fail++; $display("FAIL reset_run got %b exp 0", game_run); end
    n_tests++; if (game_reset !== 1'b0) begin n_fail++; $display("FAIL reset_greset got %b exp 0", game_reset); end
  endtask

  task automatic test_menu_nav();
    logic [1:0] exp_dn[3] = '{2'd1, 2'd2, 2'd0};
    logic [1:0] exp_up[3] = '{2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 3; i++) begin
      pulse(4'b0001, 1'b0, 1'b0);
      n_tests++; if (icon_highlighter !== exp_dn[i]) begin n_fail++; $display("FAIL menu_down%0d got %0d exp %0d", i, icon_highlighter, exp_dn[i]); end
      n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL menu_down_mode got %b exp 00", screen_mode); end
    end
    for (int i = 0; i < 3; i++) begin
      pulse(4'b0010, 1'b0, 1'b0);
      n_tests++; if (icon_highlighter !== exp_up[i]) begin n_fail++; $display("FAIL menu_up%0d got %0d exp %0d", i, icon_highlighter, exp_up[i]); end
    end
  endtask

  task automatic test_game_entry();
    pulse(4'b0100, 1'b0, 1'b0);
    tick(3);
    n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL entry_wait_mode got %b exp 00", screen_mode); end
    pulse(4'b0000, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b01) begin n_fail++; $display("FAIL entry_mode got %b exp 01", screen_mode); end
    n_tests++; if (game_reset !== 1'b1) begin n_fail++; $display("FAIL entry_greset got %b exp 1", game_reset); end
    n_tests++; if (icon_highlighter !== 2'b00) begin n_fail++; $display("FAIL entry_icon got %0d exp 0", icon_highlighter); end
    tick(1);
    n_tests++; if (game_reset !== 1'b0) begin n_fail++; $display("FAIL entry_greset_drop got %b exp 0", game_reset); end
    n_tests++; if (game_run !== 1'b1) begin n_fail++; $display("FAIL entry_run got %b exp 1", game_run); end
  endtask

  task automatic test_hold();
    pulse(4'b0000, 1'b0, 1'b1);
    n_tests++; if (game_run !== 1'b0) begin n_fail++; $display("FAIL hold_run got %b exp 0", game_run); end
    for (int i = 1; i <= 3; i++) begin
      pulse(4'b0000, 1'b1, 1'b0);
      n_tests++; if (screen_mode !== 2'b01) begin n_fail++; $display("FAIL hold_mode%0d got %b exp 01", i, screen_mode); end
    end
    tick(1);
    pulse(4'b0000, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL hold_exit_mode got %b exp 00", screen_mode); end
    n_tests++; if (icon_highlighter !== 2'b00) begin n_fail++; $display("FAIL hold_exit_icon got %0d exp 0", icon_highlighter); end
  endtask

  task automatic test_options();
    logic [1:0] exp_spd[3] = '{2'b10, 2'b00, 2'b01};
    pulse(4'b0001, 1'b0, 1'b0);
    pulse(4'b0100, 1'b0, 1'b0);
    pulse(4'b0000, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b11) begin n_fail++; $display("FAIL opt_mode got %b exp 11", screen_mode); end
    n_tests++; if (icon_highlighter !== 2'b00) begin n_fail++; $display("FAIL opt_icon got %0d exp 0", icon_highlighter); end
    for (int i = 0; i < 3; i++) begin
      pulse(4'b0100, 1'b0, 1'b0);
      n_tests++; if (speed_selector !== exp_spd[i]) begin n_fail++; $display("FAIL opt_speed%0d got %b exp %b", i, speed_selector, exp_spd[i]); end
    end
    // Back outranks select on the SPEED row: no speed step, leave for MENU.
    pulse(4'b1100, 1'b0, 1'b0);
    n_tests++; if (speed_selector !== 2'b01) begin n_fail++; $display("FAIL opt_prio_speed got %b exp 01", speed_selector); end
    n_tests++; if (screen_mode !== 2'b11) begin n_fail++; $display("FAIL opt_back_wait got %b exp 11", screen_mode); end
    pulse(4'b0000, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL opt_back_mode got %b exp 00", screen_mode); end
    n_tests++; if (icon_highlighter !== 2'b01) begin n_fail++; $display("FAIL opt_back_icon got %0d exp 1", icon_highlighter); end
  endtask

  task automatic test_same_cycle_vblank();
    pulse(4'b0010, 1'b0, 1'b0);
    pulse(4'b0100, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL samecyc_mode got %b exp 00", screen_mode); end
    pulse(4'b0000, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b01) begin n_fail++; $display("FAIL samecyc_commit got %b exp 01", screen_mode); end
    pulse(4'b1000, 1'b0, 1'b0);
    n_tests++; if (game_run !== 1'b0) begin n_fail++; $display("FAIL game_back_run got %b exp 0", game_run); end
    pulse(4'b0000, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL game_back_mode got %b exp 00", screen_mode); end
  endtask

  task automatic test_priority();
    pulse(4'b0010, 1'b0, 1'b0);
    pulse(4'b0100, 1'b0, 1'b0);
    pulse(4'b0000, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b10) begin n_fail++; $display("FAIL credits_mode got %b exp 10", screen_mode); end
    pulse(4'b1100, 1'b0, 1'b0);
    pulse(4'b0000, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL credits_exit_mode got %b exp 00", screen_mode); end
    n_tests++; if (icon_highlighter !== 2'b10) begin n_fail++; $display("FAIL credits_exit_icon got %0d exp 2", icon_highlighter); end
    pulse(4'b0011, 1'b0, 1'b0);
    n_tests++; if (icon_highlighter !== 2'b10) begin n_fail++; $display("FAIL updown_icon got %0d exp 2", icon_highlighter); end
  endtask

  task automatic test_reset_pending();
    pulse(4'b0001, 1'b0, 1'b0);
    pulse(4'b0100, 1'b0, 1'b0);
    do_reset();
    n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL rstpend_mode got %b exp 00", screen_mode); end
    n_tests++; if (speed_selector !== 2'b01) begin n_fail++; $display("FAIL rstpend_speed got %b exp 01", speed_selector); end
    pulse(4'b0000, 1'b1, 1'b0);
    n_tests++; if (screen_mode !== 2'b00) begin n_fail++; $display("FAIL rstpend_vblnk_mode got %b exp 00", screen_mode); end
    n_tests++; if (game_reset !== 1'b0) begin n_fail++; $display("FAIL rstpend_greset got %b exp 0", game_reset); end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] mask;
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        mask = (r < 45) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(1, 15));
        model_btn(mask);
        pulse(mask, 1'b0, 1'b0);
      end else if (r < 85) begin
        model_vblnk();
        pulse(4'b0000, 1'b1, 1'b0);
      end else begin
        model_game_over();
        pulse(4'b0000, 1'b0, 1'b1);
      end
      n_tests++; if (screen_mode !== 2'(m_mode)) begin n_fail++; $display("FAIL rnd%0d_mode got %0d exp %0d", i, screen_mode, m_mode); end
      n_tests++; if (icon_highlighter !== 2'(m_icon)) begin n_fail++; $display("FAIL rnd%0d_icon got %0d exp %0d", i, icon_highlighter, m_icon); end
      n_tests++; if (speed_selector !== 2'(m_speed)) begin n_fail++; $display("FAIL rnd%0d_speed got %0d exp %0d", i, speed_selector, m_speed); end
      n_tests++; if (game_run !== (m_mode == 1 && !m_pend && m_hold < 0)) begin n_fail++; $display("FAIL rnd%0d_run got %b exp %b", i, game_run, (m_mode == 1 && !m_pend && m_hold < 0)); end
      n_tests++; if (game_reset !== m_greset) begin n_fail++; $display("FAIL rnd%0d_greset got %b exp %b", i, game_reset, m_greset); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    tick(1);
    test_reset();
    test_menu_nav();
    test_game_entry();
    test_hold();
    test_options();
    test_same_cycle_vblank();
    test_priority();
    test_reset_pending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
